// File: rtl/efb_tc_pkg.sv
// Shared definitions for the EFB timer/counter programming sequencer:
// register map, FSM encoding and the fixed programming script.
package efb_tc_pkg;

    localparam logic [7:0] ADR_TCCR0     = 8'h5E;
    localparam logic [7:0] ADR_TCCR1     = 8'h5F;
    localparam logic [7:0] ADR_TCTOPSET0 = 8'h60;
    localparam logic [7:0] ADR_TCTOPSET1 = 8'h61;
    localparam logic [7:0] ADR_TCOCRSET0 = 8'h62;
    localparam logic [7:0] ADR_TCOCRSET1 = 8'h63;

    localparam int         SCRIPT_LEN = 7;
    localparam logic [2:0] LAST_STEP  = 3'(SCRIPT_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_GAP,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } tc_state_e;

    typedef struct packed {
        logic       we;
        logic [7:0] adr;
        logic [7:0] dat;
    } wb_op_t;

    // TCCR1 goes last so the counter is only enabled once top/compare are loaded;
    // the final step reads TCTOPSET0 back.
    function automatic wb_op_t script_op(
        input logic [2:0]  step,
        input logic [15:0] top,
        input logic [15:0] ocr,
        input logic [7:0]  tccr0,
        input logic [7:0]  tccr1
    );
        wb_op_t op;
        op = '{we: 1'b0, adr: ADR_TCTOPSET0, dat: 8'h00};
        case (step)
            3'd0: op = '{we: 1'b1, adr: ADR_TCCR0,     dat: tccr0};
            3'd1: op = '{we: 1'b1, adr: ADR_TCTOPSET0, dat: top[7:0]};
            3'd2: op = '{we: 1'b1, adr: ADR_TCTOPSET1, dat: top[15:8]};
            3'd3: op = '{we: 1'b1, adr: ADR_TCOCRSET0, dat: ocr[7:0]};
            3'd4: op = '{we: 1'b1, adr: ADR_TCOCRSET1, dat: ocr[15:8]};
            3'd5: op = '{we: 1'b1, adr: ADR_TCCR1,     dat: tccr1};
            default: op = '{we: 1'b0, adr: ADR_TCTOPSET0, dat: 8'h00};
        endcase
        return op;
    endfunction

endpackage

// File: rtl/efb_wb_xact.sv
// Single Wishbone classic transaction engine with an ack timeout.
// Bus outputs are registered; ok/tout are valid only while stb is high.
module efb_wb_xact #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       we,
    input  logic [7:0] adr,
    input  logic [7:0] wdat,
    output logic [7:0] rdat,
    output logic       ok,
    output logic       tout,
    output logic       wb_cyc,
    output logic       wb_stb,
    output logic       wb_we,
    output logic [7:0] wb_adr,
    output logic [7:0] wb_wdat,
    input  logic [7:0] wb_rdat,
    input  logic       wb_ack
);

    logic [7:0] cnt_q;

    // An ack with no strobe outstanding is never seen by the sequencer.
    assign ok   = wb_stb & wb_ack;
    assign tout = wb_stb & ~wb_ack & (cnt_q == 8'd1);
    assign rdat = wb_rdat;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_cyc  <= 1'b0;
            wb_stb  <= 1'b0;
            wb_we   <= 1'b0;
            wb_adr  <= 8'h00;
            wb_wdat <= 8'h00;
            cnt_q   <= 8'h00;
        end else if (go) begin
            wb_cyc  <= 1'b1;
            wb_stb  <= 1'b1;
            wb_we   <= we;
            wb_adr  <= adr;
            wb_wdat <= wdat;
            cnt_q   <= 8'(ACK_TIMEOUT);
        end else if (ok || tout) begin
            wb_cyc  <= 1'b0;
            wb_stb  <= 1'b0;
        end else if (wb_stb) begin
            cnt_q   <= cnt_q - 8'd1;
        end
    end

endmodule

// File: rtl/efb_tc_sequencer.sv
// Wishbone master that programs the MachXO2 EFB timer/counter with a runtime
// top/compare value, reads TCTOPSET0 back and reports done or error.
module efb_tc_sequencer
    import efb_tc_pkg::*;
#(
    parameter int         ACK_TIMEOUT = 255,
    parameter logic [7:0] TCCR0_VAL   = 8'h08,
    parameter logic [7:0] TCCR1_VAL   = 8'h05
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [15:0] top_i,
    input  logic [15:0] ocr_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [7:0]  wb_adr_o,
    output logic [7:0]  wb_dat_o,
    input  logic [7:0]  wb_dat_i,
    input  logic        wb_ack_i,
    output logic        busy,
    output logic        done,
    output logic        error,
    output tc_state_e   fsm_state
);

    tc_state_e   state_q, state_n;
    logic [2:0]  step_q, step_n;
    logic [15:0] top_q, ocr_q;
    logic        busy_q, done_q, error_q;
    logic        accept, go;
    logic        x_ok, x_tout;
    logic [7:0]  x_rdat;
    wb_op_t      op;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // ISSUE is the first strobe cycle; the read step waits in CHECK so the
    // readback is compared on the very edge its ack arrives.
    always_comb begin
        state_n = state_q;
        step_n  = step_q;
        accept  = 1'b0;
        go      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    go      = 1'b1;
                    step_n  = 3'd0;
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE, ST_WAIT_ACK, ST_CHECK: begin
                if (x_tout) begin
                    state_n = ST_ERR;
                end else if (x_ok) begin
                    if (step_q == LAST_STEP) begin
                        state_n = (x_rdat == top_q[7:0]) ? ST_DONE : ST_ERR;
                    end else begin
                        state_n = ST_GAP;
                    end
                end else if (state_q == ST_ISSUE) begin
                    state_n = (step_q == LAST_STEP) ? ST_CHECK : ST_WAIT_ACK;
                end
            end
            ST_GAP: begin
                go      = 1'b1;
                step_n  = step_q + 3'd1;
                state_n = ST_ISSUE;
            end
            ST_DONE, ST_ERR: state_n = ST_IDLE;
            default:         state_n = ST_IDLE;
        endcase
        op = script_op(step_n, top_q, ocr_q, TCCR0_VAL, TCCR1_VAL);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            step_q  <= 3'd0;
            top_q   <= 16'h0000;
            ocr_q   <= 16'h0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            step_q <= step_n;
            if (accept) begin
                top_q <= top_i;
                ocr_q <= ocr_i;
            end
            busy_q <= (state_n == ST_ISSUE) || (state_n == ST_WAIT_ACK) ||
                      (state_n == ST_GAP)   || (state_n == ST_CHECK);
            done_q <= (state_n == ST_DONE);
            if (accept) begin
                error_q <= 1'b0;
            end else if (state_n == ST_ERR) begin
                error_q <= 1'b1;
            end
        end
    end

    efb_wb_xact #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_xact (
        .clk     (CLK),
        .rst     (RESET),
        .go      (go),
        .we      (op.we),
        .adr     (op.adr),
        .wdat    (op.dat),
        .rdat    (x_rdat),
        .ok      (x_ok),
        .tout    (x_tout),
        .wb_cyc  (wb_cyc_o),
        .wb_stb  (wb_stb_o),
        .wb_we   (wb_we_o),
        .wb_adr  (wb_adr_o),
        .wb_wdat (wb_dat_o),
        .wb_rdat (wb_dat_i),
        .wb_ack  (wb_ack_i)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_efb_tc_sequencer.sv
// Self-checking bench for efb_tc_sequencer: configurable-latency slave,
// per-cycle arithmetic timing model and a transaction scoreboard.
module tb_efb_tc_sequencer;
    import efb_tc_pkg::*;

    localparam int TOUT = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0;
    logic [15:0] top_i = 16'h0000;
    logic [15:0] ocr_i = 16'h0000;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [7:0]  wb_adr_o, wb_dat_o;
    logic [7:0]  wb_dat_i = 8'h00;
    logic        wb_ack_i = 1'b0;
    logic        busy, done, error;
    tc_state_e   fsm_state;

    efb_tc_sequencer #(
        .ACK_TIMEOUT(TOUT)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (start),
        .top_i     (top_i),
        .ocr_i     (ocr_i),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .fsm_state (fsm_state)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // scenario and slave state
    int          lat, hang, stb_cnt, xact_idx;
    bit          bad;
    logic [15:0] cur_top;
    int          last_done_c, last_err_c;
    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];
    logic [16:0] last_obs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // {we, adr, dat} for script step k
    function automatic logic [16:0] exp_op(input int k, input logic [15:0] t, input logic [15:0] o);
        case (k)
            0: return {1'b1, 8'h5E, 8'h08};
            1: return {1'b1, 8'h60, t[7:0]};
            2: return {1'b1, 8'h61, t[15:8]};
            3: return {1'b1, 8'h62, o[7:0]};
            4: return {1'b1, 8'h63, o[15:8]};
            5: return {1'b1, 8'h5F, 8'h05};
            default: return {1'b0, 8'h60, 8'h00};
        endcase
    endfunction

    // Expected outputs at cycle c after the start edge, from the step cost
    // (lat + 2 cycles) and the abort/readback rules.
    task automatic model_check(input int c, input logic [15:0] t, input logic [15:0] o);
        int per, k;
        bit e_busy, e_done, e_err, e_stb;
        logic [16:0] e_op;
        per = lat + 2;
        k = 0;
        e_busy = 0; e_done = 0; e_err = 0; e_stb = 0;
        if (hang >= 0 && c >= 1 + hang * per) begin
            if (c < 1 + hang * per + TOUT) begin
                e_stb = 1; e_busy = 1; k = hang;
            end else begin
                e_err = 1;
            end
        end else if (c < 7 * per) begin
            k = (c - 1) / per;
            e_stb = ((c - 1) % per) <= lat;
            e_busy = 1;
        end else if (c == 7 * per) begin
            e_done = !bad;
            e_err = bad;
        end else begin
            e_err = bad;
        end
        check($sformatf("busy c=%0d", c), 32'(busy), 32'(e_busy));
        check($sformatf("done c=%0d", c), 32'(done), 32'(e_done));
        check($sformatf("error c=%0d", c), 32'(error), 32'(e_err));
        check($sformatf("stb c=%0d", c), 32'(wb_stb_o), 32'(e_stb));
        check($sformatf("cyc c=%0d", c), 32'(wb_cyc_o), 32'(e_stb));
        if (e_stb) begin
            e_op = exp_op(k, t, o);
            check($sformatf("bus_op c=%0d", c), 32'({wb_we_o, wb_adr_o, wb_dat_o}), 32'(e_op));
        end
    endtask

    // Slave acks on the lat-th strobe cycle, except for the hung transaction.
    task automatic slave_drive(input bit noise);
        bit ack;
        if (wb_stb_o) begin
            ack = (stb_cnt == lat) && (xact_idx != hang);
            stb_cnt++;
            wb_dat_i = (ack && !wb_we_o) ? (bad ? (cur_top[7:0] ^ 8'h01) : cur_top[7:0])
                                         : 8'($urandom);
            if (ack) begin
                obs_q.push_back({wb_we_o, wb_adr_o, wb_dat_o});
                xact_idx++;
            end
        end else begin
            stb_cnt = 0;
            ack = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            wb_dat_i = 8'($urandom);
        end
        wb_ack_i = ack;
    endtask

    task automatic run(input int l, input logic [15:0] t, input logic [15:0] o, input int h,
                       input bit b, input bit noise, input int restart_c, input int reset_c);
        int per, total, n_exp, done_n, done_c, err_c;
        logic [16:0] got;
        per = l + 2;
        lat = l; hang = h; bad = b; cur_top = t;
        stb_cnt = 0; xact_idx = 0;
        obs_q.delete(); exp_q.delete();
        done_n = 0; done_c = -1; err_c = -1;
        total = (h >= 0) ? 1 + h * per + TOUT + 3 : 7 * per + 3;
        @(negedge CLK);
        top_i = t; ocr_i = o; start = 1'b1; wb_ack_i = 1'b0;
        for (int c = 1; c <= total; c++) begin
            @(negedge CLK);
            start = (c == restart_c);
            top_i = 16'($urandom);
            ocr_i = 16'($urandom);
            if (reset_c >= 0 && c == reset_c + 1) begin
                check("rst_cyc", 32'(wb_cyc_o), 32'd0);
                check("rst_stb", 32'(wb_stb_o), 32'd0);
                check("rst_we", 32'(wb_we_o), 32'd0);
                check("rst_adr", 32'(wb_adr_o), 32'd0);
                check("rst_dat", 32'(wb_dat_o), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_error", 32'(error), 32'd0);
                check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
                RESET = 1'b0;
                break;
            end
            model_check(c, t, o);
            if (done) begin
                done_n++;
                if (done_c < 0) done_c = c;
            end
            if (error && err_c < 0) err_c = c;
            slave_drive(noise);
            if (c == reset_c) RESET = 1'b1;
        end
        wb_ack_i = 1'b0;
        n_exp = (reset_c >= 0) ? (reset_c - 1) / per : ((h >= 0) ? h : 7);
        for (int i = 0; i < n_exp; i++) exp_q.push_back(exp_op(i, t, o));
        last_obs = obs_q;
        check("xact_count", 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            got = obs_q.pop_front();
            check("xact", 32'(got), 32'(exp_q.pop_front()));
        end
        if (reset_c < 0) begin
            check("end_state_idle", 32'(fsm_state), 32'(ST_IDLE));
            check("done_pulses", 32'(done_n), 32'((h < 0 && !b) ? 1 : 0));
        end
        last_done_c = done_c;
        last_err_c = err_c;
    endtask

    logic [16:0] lit_ops [7];

    initial begin
        lit_ops = '{17'h15E08, 17'h16034, 17'h16112, 17'h162BC, 17'h1630A, 17'h15F05, 17'h06000};

        repeat (3) @(negedge CLK);
        check("reset_stb", 32'(wb_stb_o), 32'd0);
        check("reset_cyc", 32'(wb_cyc_o), 32'd0);
        check("reset_adr_dat_we", 32'({wb_we_o, wb_adr_o, wb_dat_o}), 32'd0);
        check("reset_flags", 32'({busy, done, error}), 32'd0);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        check("idle_busy", 32'(busy), 32'd0);

        // nominal run
        run(1, 16'h1234, 16'h0ABC, -1, 0, 0, -1, -1);
        check("pin_done_cycle", 32'(last_done_c), 32'd21);
        check("pin_op_count", 32'(last_obs.size()), 32'd7);
        for (int i = 0; i < 7 && i < last_obs.size(); i++)
            check($sformatf("pin_op%0d", i), 32'(last_obs[i]), 32'(lit_ops[i]));

        // readback mismatch
        run(1, 16'h1234, 16'h0ABC, -1, 1, 0, -1, -1);
        check("pin_mismatch_err_cycle", 32'(last_err_c), 32'd21);

        // no ack on step 2
        run(1, 16'h1234, 16'h0ABC, 2, 0, 0, -1, -1);
        check("pin_timeout_err_cycle", 32'(last_err_c), 32'd11);

        // start pulsed during step 3
        run(1, 16'($urandom), 16'($urandom), -1, 0, 0, 11, -1);

        // reset while step 4 strobes, then a full rerun
        run(1, 16'($urandom), 16'($urandom), -1, 0, 0, -1, 13);
        repeat (2) @(negedge CLK);
        run(1, 16'($urandom), 16'($urandom), -1, 0, 0, -1, -1);

        // slow slave
        run(3, 16'($urandom), 16'($urandom), -1, 0, 0, -1, -1);
        check("pin_slow_done_cycle", 32'(last_done_c), 32'd35);

        for (int r = 0; r < 8; r++) begin
            int l, h;
            bit b;
            l = $urandom_range(0, 3);
            h = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : -1;
            b = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(1, 3)) @(negedge CLK);
            run(l, 16'($urandom), 16'($urandom), h, b, 1, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
